// File: rtl/conv_deinterleaver_if.sv
// Byte-stream bundle for the convolutional deinterleaver: received bytes in,
// deinterleaved bytes plus status strobes out.
interface conv_deinterleaver_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_sync;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_sync;
  logic       sync_err;

  // Stream source / sink (e.g. a testbench or upstream demodulator)
  modport master (
    output din, din_valid, din_sync,
    input  dout, dout_valid, dout_sync, sync_err
  );

  // Deinterleaver side
  modport slave (
    input  din, din_valid, din_sync,
    output dout, dout_valid, dout_sync, sync_err
  );
endinterface

// File: rtl/conv_deinterleaver.sv
// Convolutional (Forney) deinterleaver. I commutator branches, branch j is a
// byte FIFO of depth (I-1-j)*M carved out of one shared memory. Each accepted
// byte reads the oldest byte of its branch and overwrites it in place, so a
// single pointer per branch serves as both read and write pointer.
module conv_deinterleaver #(
  parameter int I = 12,
  parameter int M = 17
) (
  input logic                 clk,
  input logic                 reset,
  conv_deinterleaver_if.slave bus
);

  localparam int DMAX = (I - 1) * M;
  localparam int MEM  = I * (I - 1) * M / 2;
  localparam int AW   = $clog2(MEM + 1);
  localparam int PW   = $clog2(DMAX + 1);
  localparam int BW   = $clog2(I);
  localparam logic [BW-1:0] BR_LAST = BW'(I - 1);

  // FIFO depth of branch j
  function automatic int depth_f(input int j);
    return (I - 1 - j) * M;
  endfunction

  // Start address of branch j: sum of depths of branches 0..j-1
  function automatic int base_f(input int j);
    return M * (j * (I - 1) - (j * (j - 1)) / 2);
  endfunction

  logic [7:0]    mem_q [MEM];
  logic [PW-1:0] ptr_q [I];
  logic [PW-1:0] fill_q [I];
  logic [BW-1:0] br_q, br_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_sync_q, dout_sync_d;
  logic          sync_err_q, sync_err_d;

  logic [BW-1:0] sel_s;
  logic [PW-1:0] d_s, ptr_cur_s, fill_cur_s, ptr_d, fill_d;
  logic [AW-1:0] addr_s;
  logic [7:0]    rd_s, out_byte_s;

  // Branch selection, memory addressing and next-state of the selected branch
  always_comb begin
    sel_s      = bus.din_sync ? '0 : br_q;
    d_s        = PW'(depth_f(int'(sel_s)));
    ptr_cur_s  = ptr_q[sel_s];
    fill_cur_s = fill_q[sel_s];
    addr_s     = AW'(base_f(int'(sel_s))) + AW'(ptr_cur_s);
    rd_s       = mem_q[addr_s];

    // Pass-through branch has no storage; unfilled branches emit zero
    if (d_s == '0) begin
      out_byte_s = bus.din;
    end else if (fill_cur_s < d_s) begin
      out_byte_s = 8'h00;
    end else begin
      out_byte_s = rd_s;
    end

    if (d_s == '0) begin
      ptr_d = ptr_cur_s;
    end else if (ptr_cur_s == d_s - PW'(1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = ptr_cur_s + PW'(1);
    end

    if (fill_cur_s < d_s) begin
      fill_d = fill_cur_s + PW'(1);
    end else begin
      fill_d = fill_cur_s;
    end
  end

  // Commutator advance and registered output strobes
  always_comb begin
    br_d         = br_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_sync_d  = 1'b0;
    sync_err_d   = 1'b0;
    if (bus.din_valid) begin
      br_d         = (sel_s == BR_LAST) ? '0 : sel_s + BW'(1);
      dout_d       = out_byte_s;
      dout_valid_d = 1'b1;
      dout_sync_d  = (sel_s == '0);
      sync_err_d   = bus.din_sync && (br_q != '0);
    end else begin
      br_d = br_q;
    end
  end

  // Control state: commutator, per-branch pointers and fill counts, outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_q         <= '0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      dout_sync_q  <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int j = 0; j < I; j++) begin
        ptr_q[j]  <= '0;
        fill_q[j] <= '0;
      end
    end else begin
      br_q         <= br_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sync_q  <= dout_sync_d;
      sync_err_q   <= sync_err_d;
      if (bus.din_valid) begin
        ptr_q[sel_s]  <= ptr_d;
        fill_q[sel_s] <= fill_d;
      end
    end
  end

  // Shared branch storage; contents are don't-care until a branch has filled
  always_ff @(posedge clk) begin
    if (bus.din_valid && (d_s != '0)) begin
      mem_q[addr_s] <= bus.din;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_sync  = dout_sync_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_conv_deinterleaver.sv
// Directed bench: a small I=3, M=2 instance (depths 4,2,0) for hand-computed
// vectors, and a default-parameter instance fed through an interleaver model.
module tb_conv_deinterleaver;

  logic clk = 1'b0;
  logic reset;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  conv_deinterleaver_if s_if ();
  conv_deinterleaver_if b_if ();

  conv_deinterleaver #(.I(3), .M(2)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if.slave)
  );

  conv_deinterleaver u_big (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  // Compare one observed value against its expectation
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs === exp_v) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock on the small instance; outputs are settled 1 time unit after the edge
  task automatic s_step(input logic v, input logic s, input logic [7:0] d);
    s_if.din_valid = v;
    s_if.din_sync  = s;
    s_if.din       = d;
    @(posedge clk);
    #1;
  endtask

  // One clock on the default-parameter instance
  task automatic b_step(input logic v, input logic s, input logic [7:0] d);
    b_if.din_valid = v;
    b_if.din_sync  = s;
    b_if.din       = d;
    @(posedge clk);
    #1;
  endtask

  // Three cycles of reset with idle inputs
  task automatic do_reset();
    reset = 1'b0;
    repeat (3) s_step(1'b0, 1'b0, 8'h00);
    reset = 1'b1;
  endtask

  // Expected small-instance output for continuous slot k: branch b delays by D(b)*I slots
  function automatic logic [7:0] exp_byte(input logic [7:0] base, input int k);
    int dly;
    dly = (2 - (k % 3)) * 2 * 3;
    if (k >= dly) return base + 8'(k - dly);
    else return 8'h00;
  endfunction

  logic [7:0] xin [3000];
  logic [7:0] iq [12][$];
  logic [7:0] ilv;

  initial begin
    reset          = 1'b0;
    s_if.din       = 8'h00;
    s_if.din_valid = 1'b0;
    s_if.din_sync  = 1'b0;
    b_if.din       = 8'h00;
    b_if.din_valid = 1'b0;
    b_if.din_sync  = 1'b0;

    // Reset held with random traffic: outputs must stay quiet
    for (int c = 0; c < 8; c++) begin
      s_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      check_val("rst_dout", 32'(s_if.dout), 32'h0);
      check_val("rst_valid", 32'(s_if.dout_valid), 32'h0);
      check_val("rst_syncerr", 32'(s_if.sync_err), 32'h0);
    end
    reset = 1'b1;

    // Continuous stream 0x10+k, sync on first byte
    for (int k = 0; k < 21; k++) begin
      s_step(1'b1, k == 0, 8'(16 + k));
      check_val($sformatf("cont_dout_%0d", k), 32'(s_if.dout), 32'(exp_byte(8'h10, k)));
      check_val($sformatf("cont_valid_%0d", k), 32'(s_if.dout_valid), 32'h1);
      check_val($sformatf("cont_dsync_%0d", k), 32'(s_if.dout_sync), 32'(k % 3 == 0));
      check_val($sformatf("cont_serr_%0d", k), 32'(s_if.sync_err), 32'h0);
    end
    s_step(1'b0, 1'b0, 8'h00);
    check_val("cont_idle_valid", 32'(s_if.dout_valid), 32'h0);

    // Gapped stream; idle cycles carry a stray sync that must be ignored
    do_reset();
    for (int k = 0; k < 21; k++) begin
      s_step(1'b1, k == 0, 8'(16 + k));
      check_val($sformatf("gap_dout_%0d", k), 32'(s_if.dout), 32'(exp_byte(8'h10, k)));
      check_val($sformatf("gap_valid_%0d", k), 32'(s_if.dout_valid), 32'h1);
      check_val($sformatf("gap_dsync_%0d", k), 32'(s_if.dout_sync), 32'(k % 3 == 0));
      s_step(1'b0, 1'b1, 8'hEE);
      check_val($sformatf("gap_idle_valid_%0d", k), 32'(s_if.dout_valid), 32'h0);
      check_val($sformatf("gap_hold_%0d", k), 32'(s_if.dout), 32'(exp_byte(8'h10, k)));
      check_val($sformatf("gap_idle_serr_%0d", k), 32'(s_if.sync_err), 32'h0);
    end

    // Resync with commutator at branch 2
    do_reset();
    for (int k = 0; k < 5; k++) begin
      s_step(1'b1, k == 0, 8'(8'h50 + k));
      check_val($sformatf("rs_pre_serr_%0d", k), 32'(s_if.sync_err), 32'h0);
    end
    s_step(1'b1, 1'b1, 8'hAA);
    check_val("rs_serr", 32'(s_if.sync_err), 32'h1);
    check_val("rs_dsync", 32'(s_if.dout_sync), 32'h1);
    check_val("rs_dout", 32'(s_if.dout), 32'h00);
    s_step(1'b1, 1'b0, 8'hBB);
    check_val("rs_b1_dout", 32'(s_if.dout), 32'h51);
    check_val("rs_b1_serr", 32'(s_if.sync_err), 32'h0);
    check_val("rs_b1_dsync", 32'(s_if.dout_sync), 32'h0);
    s_step(1'b1, 1'b0, 8'hCC);
    check_val("rs_b2_dout", 32'(s_if.dout), 32'hCC);
    s_step(1'b1, 1'b0, 8'hDD);
    check_val("rs_b0_dout", 32'(s_if.dout), 32'h00);
    check_val("rs_b0_dsync", 32'(s_if.dout_sync), 32'h1);

    // Reset in mid-stream, then restart without sync
    do_reset();
    for (int k = 0; k < 10; k++) s_step(1'b1, k == 0, 8'(8'h30 + k));
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_step(1'b1, 1'b0, 8'h3F);
      check_val($sformatf("mid_rst_valid_%0d", c), 32'(s_if.dout_valid), 32'h0);
      check_val($sformatf("mid_rst_dout_%0d", c), 32'(s_if.dout), 32'h0);
    end
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      s_step(1'b1, 1'b0, 8'(8'h40 + k));
      check_val($sformatf("restart_dout_%0d", k), 32'(s_if.dout), 32'(exp_byte(8'h40, k)));
      check_val($sformatf("restart_dsync_%0d", k), 32'(s_if.dout_sync), 32'(k % 3 == 0));
    end
    s_if.din_valid = 1'b0;

    // Default parameters through a reference interleaver (branch j delays j*17 accesses)
    for (int j = 0; j < 12; j++) begin
      for (int z = 0; z < j * 17; z++) iq[j].push_back(8'h00);
    end
    for (int k = 0; k < 3000; k++) begin
      xin[k] = 8'($urandom_range(0, 255));
      iq[k % 12].push_back(xin[k]);
      ilv = iq[k % 12].pop_front();
      b_step(1'b1, (k % 204) == 0, ilv);
      if (k >= 2244) begin
        check_val($sformatf("rand_dout_%0d", k), 32'(b_if.dout), 32'(xin[k - 2244]));
      end
      if (k % 204 == 0) begin
        check_val($sformatf("rand_dsync_%0d", k), 32'(b_if.dout_sync), 32'h1);
        check_val($sformatf("rand_serr_%0d", k), 32'(b_if.sync_err), 32'h0);
      end
    end
    b_step(1'b0, 1'b0, 8'h00);
    check_val("rand_idle_valid", 32'(b_if.dout_valid), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/conv_deinterleaver.md
CONV_DEINTERLEAVER -- requirements
Module: conv_deinterleaver

Interface
REQ-001 Parameter I, default 12, number of commutator branches (2..16).
REQ-002 Parameter M, default 17, branch unit depth in bytes (1..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately, independent of clk.
REQ-005 din  input  8  received byte.
REQ-006 din_valid  input  1  byte-accept strobe; din accepted on every clk edge with din_valid=1, no backpressure.
REQ-007 din_sync  input  1  qualifies din_valid; marks the accepted byte as belonging to branch 0.
REQ-008 dout  output  8  deinterleaved byte.
REQ-009 dout_valid  output  1  one-cycle strobe qualifying dout.
REQ-010 dout_sync  output  1  high with dout_valid when the output byte came from branch 0.
REQ-011 sync_err  output  1  one-cycle pulse on a resynchronisation event (REQ-019).

Function
REQ-012 Branch j (0..I-1) SHALL be a byte FIFO of depth D(j)=(I-1-j)*M; branch I-1 has depth 0 (pass-through).
REQ-013 Commutator counter br (0..I-1) SHALL select the branch for each accepted byte; br advances by 1 per accepted byte, wrapping I-1 -> 0.
REQ-014 Delay SHALL count only accesses of the same branch: an accepted byte re-emerges on the D(j)-th later access of branch j; cycles with din_valid=0 change no state.
REQ-015 Per access of branch j with D(j)>0: output oldest stored byte, store din, in the same cycle; for D(j)=0 output din.
REQ-016 Fill state: each branch SHALL hold a saturating fill count (0..D(j)); while fill<D(j) the branch outputs 0x00 instead of memory contents; fill increments per access until D(j).
REQ-017 Latency: dout/dout_valid/dout_sync registered; dout_valid=1 exactly one cycle after each accepted byte, 0 otherwise; dout held between strobes.
REQ-018 dout_sync SHALL be 1 when the access that produced dout was to branch 0.
REQ-019 din_valid=1 and din_sync=1: byte SHALL be routed to branch 0 regardless of br; br becomes 1 next (0 if I=1 excluded by REQ-001). If br!=0 at that edge, sync_err pulses for one cycle (registered, aligned with the dout_valid of that byte); fill counts and stored data are kept.
REQ-020 din_sync with din_valid=0 SHALL be ignored.
REQ-021 Storage SHALL be one shared memory of I*(I-1)*M/2 bytes with per-branch base offsets and per-branch read/write pointers wrapping at D(j); memory contents need not be reset.
REQ-022 Total end-to-end deinterleaver delay for branch j SHALL equal D(j)*I accepted-byte slots; together with a matching interleaver of delay j*M, every branch totals (I-1)*M*I slots.

Reset
REQ-023 While reset=0: br=0, all fill counts=0, all pointers=0, dout=0x00, dout_valid=0, dout_sync=0, sync_err=0.
REQ-024 Reset asserted mid-stream SHALL discard all buffered bytes; first accepted byte after release goes to branch 0 and all branches output 0x00 until refilled.
REQ-025 No din accepted on the clk edge at which reset is low.

Verification (I=3, M=2: D=4,2,0)
REQ-026 Reset check: hold reset=0 with random din/din_valid -> dout=0x00, dout_valid=0, sync_err=0 throughout.
REQ-027 Continuous stream: din_valid=1 every cycle, din=0x10+k for k=0..20, din_sync=1 on k=0 only -> slot 2 outputs 0x12, slot 7 outputs 0x11, slot 12 outputs 0x10 with dout_sync=1, slots 0,3,6,9 output 0x00; sync_err never pulses.
REQ-028 Gapped input: repeat REQ-027 with din_valid toggling 1,0 -> identical dout sequence on dout_valid strobes, dout_valid only the cycle after each accept.
REQ-029 Resync: after 5 bytes (br=2) assert din_sync with byte 0xAA -> byte routed to branch 0, sync_err pulses once with dout_sync=1, next byte goes to branch 1.
REQ-030 Reset mid-operation: after 10 bytes pulse reset low for 3 cycles, restart stream 0x40+k -> first 4 branch-0 and 2 branch-1 outputs are 0x00, no pre-reset byte ever reappears.
REQ-031 Default parameters: 3000 random bytes with sync every 204 bytes through a reference interleaver model -> output equals input delayed by 11*17*12=2244 accepted slots.
